// File: rtl/alu_stage_pipe.sv
// Registered execute-stage ALU with valid/ready handshakes on both sides
// and an iterative shift-add multiplier.
module alu_stage_pipe #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             In_valid,
  output logic             In_ready,
  input  logic [WIDTH-1:0] RF_A,
  input  logic [WIDTH-1:0] RF_B,
  input  logic [WIDTH-1:0] Immed,
  input  logic             ALU_Bin_SEL,
  input  logic [3:0]       ALU_func,
  output logic             Out_valid,
  input  logic             Out_ready,
  output logic [WIDTH-1:0] ALU_out,
  output logic             Zero_out,
  output logic             Ovf_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, MUL} state_e;

  state_e state_q, state_d;

  logic             ov_q, ov_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplr_q, mplr_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] res_c;
  logic             ovf_c;
  logic [WIDTH-1:0] acc_sum;
  logic             accept;
  logic             drain;
  logic             is_mul;

  logic op_add, op_sub, op_and, op_or;
  logic op_not, op_xor, op_sra, op_srl;
  logic op_sll, op_rol, op_ror;

  assign b = ALU_Bin_SEL ? Immed : RF_B;

  assign op_add = (ALU_func == 4'b0000);
  assign op_sub = (ALU_func == 4'b0001);
  assign op_and = (ALU_func == 4'b0010);
  assign op_or  = (ALU_func == 4'b0011);
  assign op_not = (ALU_func == 4'b0100);
  assign op_xor = (ALU_func == 4'b0110);
  assign op_sra = (ALU_func == 4'b1000);
  assign op_srl = (ALU_func == 4'b1001);
  assign op_sll = (ALU_func == 4'b1010);
  assign op_rol = (ALU_func == 4'b1100);
  assign op_ror = (ALU_func == 4'b1101);
  assign is_mul = MUL_EN && (ALU_func == 4'b0111);

  // Unlisted opcodes (and a disabled multiply) fall to result 0.
  always_comb begin
    res_c = '0;
    ovf_c = 1'b0;
    unique case (1'b1)
      op_add: begin
        res_c = RF_A + b;
        ovf_c = (RF_A[WIDTH-1] == b[WIDTH-1]) &&
                (res_c[WIDTH-1] != RF_A[WIDTH-1]);
      end
      op_sub: begin
        res_c = RF_A - b;
        ovf_c = (RF_A[WIDTH-1] != b[WIDTH-1]) &&
                (res_c[WIDTH-1] != RF_A[WIDTH-1]);
      end
      op_and: res_c = RF_A & b;
      op_or:  res_c = RF_A | b;
      op_not: res_c = ~RF_A;
      op_xor: res_c = RF_A ^ b;
      op_sra: res_c = {RF_A[WIDTH-1], RF_A[WIDTH-1:1]};
      op_srl: res_c = {1'b0, RF_A[WIDTH-1:1]};
      op_sll: res_c = {RF_A[WIDTH-2:0], 1'b0};
      op_rol: res_c = {RF_A[WIDTH-2:0], RF_A[WIDTH-1]};
      op_ror: res_c = {RF_A[0], RF_A[WIDTH-1:1]};
      default: ;
    endcase
  end

  assign In_ready = (state_q == IDLE) && (!ov_q || Out_ready);
  assign accept   = In_valid && In_ready;
  assign drain    = ov_q && Out_ready;
  assign acc_sum  = acc_q + (mplr_q[0] ? mcand_q : '0);

  always_comb begin
    state_d = state_q;
    ov_d    = ov_q;
    res_d   = res_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    if (drain) ov_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_mul) begin
            mcand_d = RF_A;
            mplr_d  = b;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = MUL;
          end else begin
            res_d  = res_c;
            zero_d = (res_c == '0);
            ovf_d  = ovf_c;
            ov_d   = 1'b1;
          end
        end
      end
      MUL: begin
        acc_d   = acc_sum;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        // Output is free here: accept needed it empty or draining.
        if (cnt_q == LAST) begin
          res_d   = acc_sum;
          zero_d  = (acc_sum == '0);
          ovf_d   = 1'b0;
          ov_d    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      ov_q    <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ov_q    <= ov_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Out_valid = ov_q;
  assign ALU_out   = res_q;
  assign Zero_out  = zero_q;
  assign Ovf_out   = ovf_q;

endmodule

// File: tb/tb_alu_stage_pipe.sv
// Bench for alu_stage_pipe: directed cases plus randomized traffic
// scored against a cycle-level behavioural model.
module tb_alu_stage_pipe;

  localparam int W = 32;

  logic         Clk = 1'b0;
  logic         Reset_n;
  logic         In_valid;
  logic         In_ready;
  logic [W-1:0] RF_A;
  logic [W-1:0] RF_B;
  logic [W-1:0] Immed;
  logic         ALU_Bin_SEL;
  logic [3:0]   ALU_func;
  logic         Out_valid;
  logic         Out_ready;
  logic [W-1:0] ALU_out;
  logic         Zero_out;
  logic         Ovf_out;

  logic         nm_in_ready;
  logic         nm_valid;
  logic [W-1:0] nm_out;
  logic         nm_zero;
  logic         nm_ovf;

  always #5 Clk = ~Clk;

  alu_stage_pipe #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .In_valid(In_valid), .In_ready(In_ready),
    .RF_A(RF_A), .RF_B(RF_B), .Immed(Immed),
    .ALU_Bin_SEL(ALU_Bin_SEL), .ALU_func(ALU_func),
    .Out_valid(Out_valid), .Out_ready(Out_ready),
    .ALU_out(ALU_out), .Zero_out(Zero_out), .Ovf_out(Ovf_out)
  );

  alu_stage_pipe #(.WIDTH(W), .MUL_EN(1'b0)) u_nomul (
    .Clk(Clk), .Reset_n(Reset_n),
    .In_valid(In_valid), .In_ready(nm_in_ready),
    .RF_A(RF_A), .RF_B(RF_B), .Immed(Immed),
    .ALU_Bin_SEL(ALU_Bin_SEL), .ALU_func(ALU_func),
    .Out_valid(nm_valid), .Out_ready(Out_ready),
    .ALU_out(nm_out), .Zero_out(nm_zero), .Ovf_out(nm_ovf)
  );

  int n_cmp = 0;
  int n_err = 0;

  // model state
  logic         m_ov;
  logic [W-1:0] m_res;
  logic         m_ovf;
  logic [W-1:0] p_res;
  int           m_busy;
  logic         m_acc;

  task automatic check(input string tag,
                       input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [W:0] ref_op(input logic [W-1:0] a,
                                        input logic [W-1:0] b,
                                        input logic [3:0]   f);
    logic [W-1:0] r;
    logic         o;
    r = '0;
    o = 1'b0;
    case (f)
      4'h0: begin
        r = a + b;
        o = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      4'h1: begin
        r = a - b;
        o = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      4'h2: r = a & b;
      4'h3: r = a | b;
      4'h4: r = ~a;
      4'h6: r = a ^ b;
      4'h7: r = a * b;
      4'h8: r = W'($signed(a) >>> 1);
      4'h9: r = a >> 1;
      4'hA: r = a << 1;
      4'hC: r = (a << 1) | (a >> (W - 1));
      4'hD: r = (a >> 1) | (a << (W - 1));
      default: r = '0;
    endcase
    return {o, r};
  endfunction

  task automatic model_reset();
    m_ov   = 1'b0;
    m_res  = '0;
    m_ovf  = 1'b0;
    p_res  = '0;
    m_busy = 0;
    m_acc  = 1'b0;
  endtask

  // One clock cycle: drive, check In_ready, advance model, check outputs.
  task automatic cyc(input logic v, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [W-1:0] im,
                     input logic sel, input logic [3:0] f,
                     input logic ordy);
    logic       rdy;
    logic       drn;
    logic [W:0] r;
    @(negedge Clk);
    In_valid    = v;
    RF_A        = a;
    RF_B        = b;
    Immed       = im;
    ALU_Bin_SEL = sel;
    ALU_func    = f;
    Out_ready   = ordy;
    #1;
    rdy = (m_busy == 0) && (!m_ov || ordy);
    check("in_ready", W'(In_ready), W'(rdy));
    @(posedge Clk);
    drn   = m_ov && ordy;
    m_acc = v && rdy;
    if (drn) m_ov = 1'b0;
    if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        m_ov  = 1'b1;
        m_res = p_res;
        m_ovf = 1'b0;
      end
    end else if (m_acc) begin
      r = ref_op(a, sel ? im : b, f);
      if (f == 4'h7) begin
        m_busy = W;
        p_res  = r[W-1:0];
      end else begin
        m_ov  = 1'b1;
        m_res = r[W-1:0];
        m_ovf = r[W];
      end
    end
    #1;
    check("out_valid", W'(Out_valid), W'(m_ov));
    if (m_ov) begin
      check("alu_out", ALU_out, m_res);
      check("zero_out", W'(Zero_out), W'(m_res == '0));
      check("ovf_out", W'(Ovf_out), W'(m_ovf));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, '0, 1'b0, 4'h0, 1'b1);
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return W'($urandom);
    endcase
  endfunction

  logic         hv;
  logic [W-1:0] ha, hb, hi;
  logic         hs;
  logic [3:0]   hf;

  initial begin
    Reset_n     = 1'b0;
    In_valid    = 1'b0;
    RF_A        = '0;
    RF_B        = '0;
    Immed       = '0;
    ALU_Bin_SEL = 1'b0;
    ALU_func    = 4'h0;
    Out_ready   = 1'b1;
    model_reset();
    #3;
    check("rst_valid", W'(Out_valid), '0);
    check("rst_out", ALU_out, '0);
    check("rst_zero", W'(Zero_out), '0);
    check("rst_ovf", W'(Ovf_out), '0);
    @(negedge Clk);
    Reset_n = 1'b1;

    // add with overflow via immediate, then sub to zero
    cyc(1'b1, 32'h7FFF_FFFF, 32'hDEAD_BEEF, 32'h1, 1'b1, 4'h0, 1'b1);
    check("add_res", ALU_out, 32'h8000_0000);
    check("add_ovf", W'(Ovf_out), W'(1));
    check("add_zero", W'(Zero_out), '0);
    cyc(1'b1, 32'h1234_5678, 32'h1234_5678, 32'h5, 1'b0, 4'h1, 1'b1);
    check("sub_res", ALU_out, '0);
    check("sub_zero", W'(Zero_out), W'(1));
    check("sub_ovf", W'(Ovf_out), '0);

    // back-to-back throughput
    cyc(1'b1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, '0, 1'b0, 4'h2, 1'b1);
    check("b2b_and", ALU_out, 32'h00F0_00F0);
    cyc(1'b1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, '0, 1'b0, 4'h3, 1'b1);
    check("b2b_or", ALU_out, 32'hFFF0_FFF0);
    cyc(1'b1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, '0, 1'b0, 4'h6, 1'b1);
    check("b2b_xor", ALU_out, 32'hFF00_FF00);
    cyc(1'b1, 32'h8000_0001, '0, '0, 1'b0, 4'h8, 1'b1);
    check("b2b_sra", ALU_out, 32'hC000_0000);
    idle(1);

    // stall: result held, then drain and accept on one edge
    cyc(1'b1, 32'h0000_00AA, '0, '0, 1'b0, 4'hA, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 32'h1, '0, '0, 1'b0, 4'hC, 1'b0);
      check("stall_rdy", W'(In_ready), '0);
      check("stall_hold", ALU_out, 32'h0000_0154);
    end
    cyc(1'b1, 32'h1, '0, '0, 1'b0, 4'hC, 1'b1);
    check("stall_new", ALU_out, 32'h0000_0002);
    idle(1);

    // multiply; the no-multiply instance sees the same 0111
    cyc(1'b1, 32'hFFFF_FFFF, 32'h3, '0, 1'b0, 4'h7, 1'b1);
    check("nomul_valid", W'(nm_valid), W'(1));
    check("nomul_out", nm_out, '0);
    check("nomul_zero", W'(nm_zero), W'(1));
    check("mul_start", W'(Out_valid), '0);
    idle(W);
    check("mul_valid", W'(Out_valid), W'(1));
    check("mul_res", ALU_out, 32'hFFFF_FFFD);
    cyc(1'b1, 32'h0001_0000, '0, 32'h0001_0000, 1'b1, 4'h7, 1'b1);
    idle(W);
    check("mul2_res", ALU_out, '0);
    check("mul2_zero", W'(Zero_out), W'(1));

    // unsupported opcode and rotate right
    cyc(1'b1, 32'h1234_5678, 32'h1, '0, 1'b0, 4'hF, 1'b1);
    check("bad_res", ALU_out, '0);
    check("bad_zero", W'(Zero_out), W'(1));
    cyc(1'b1, 32'h1, '0, '0, 1'b0, 4'hD, 1'b1);
    check("ror_res", ALU_out, 32'h8000_0000);

    // async reset while a result is stalled
    cyc(1'b1, 32'h5, 32'h6, '0, 1'b0, 4'h0, 1'b0);
    @(negedge Clk);
    #2;
    Reset_n = 1'b0;
    model_reset();
    #1;
    check("arst_valid", W'(Out_valid), '0);
    check("arst_out", ALU_out, '0);
    check("arst_zero", W'(Zero_out), '0);
    check("arst_ovf", W'(Ovf_out), '0);
    @(negedge Clk);
    Reset_n = 1'b1;
    Out_ready = 1'b0;
    #1;
    check("arst_rdy", W'(In_ready), W'(1));

    // reset mid-multiply: no result may appear afterwards
    cyc(1'b1, 32'h7, 32'h9, '0, 1'b0, 4'h7, 1'b1);
    idle(10);
    #2;
    Reset_n = 1'b0;
    model_reset();
    #1;
    check("mrst_valid", W'(Out_valid), '0);
    @(negedge Clk);
    Reset_n = 1'b1;
    idle(W + 4);

    // randomized traffic; upstream holds inputs until accepted
    hv = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!hv || m_acc) begin
        hv = ($urandom_range(0, 3) != 0);
        ha = pick_operand();
        hb = pick_operand();
        hi = pick_operand();
        hs = $urandom_range(0, 1) != 0;
        hf = ($urandom_range(0, 9) == 0) ? 4'h7
                                         : 4'($urandom_range(0, 15));
      end
      m_acc = 1'b0;
      cyc(hv, ha, hb, hi, hs, hf, $urandom_range(0, 3) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_stage_pipe.md
Name: alu_stage_pipe

Overview:
- Parametrised, registered successor to the combinational execute-stage ALU.
- Selects operand B from RF_B or Immed and computes the ALU_func result, as before.
- Adds registered outputs, a valid/ready handshake on both sides, an overflow flag and an iterative shift-add multiply.
- Sits between decode and memory stages; the pipeline stalls via the ready signals.

Parameters:
- WIDTH, 32, datapath width in bits (≥ 4).
- MUL_EN, 1, 1 = ALU_func 0111 performs a multi-cycle multiply; 0 = 0111 treated as unsupported.

Ports:
- Clk  in  1  rising-edge clock
- Reset_n  in  1  asynchronous active-low reset
- In_valid  in  1  operands/function valid
- In_ready  out  1  stage can accept an operation this cycle
- RF_A  in  WIDTH  operand A
- RF_B  in  WIDTH  register operand B
- Immed  in  WIDTH  immediate operand B
- ALU_Bin_SEL  in  1  0 = RF_B, 1 = Immed
- ALU_func  in  4  operation code
- Out_valid  out  1  result registers hold a valid result
- Out_ready  in  1  consumer accepts the result this cycle
- ALU_out  out  WIDTH  registered result
- Zero_out  out  1  registered (ALU_out == 0)
- Ovf_out  out  1  registered signed overflow (add/sub only, else 0)

Behaviour:
- Reset (async, Reset_n = 0): state IDLE, Out_valid = 0, ALU_out = 0, Zero_out = 0, Ovf_out = 0, multiply counter = 0, operand registers = 0. Reset mid-multiply aborts the multiply with no output.
- Accept: occurs on a rising edge with In_valid && In_ready.
- In_ready = (state == IDLE) && (!Out_valid || Out_ready). This is combinational; simultaneous drain and accept in the same cycle is legal.
- Drain: occurs on a rising edge with Out_valid && Out_ready. Out_valid clears unless a single-cycle result is loaded on the same edge. ALU_out, Zero_out and Ovf_out hold stable while Out_valid && !Out_ready.
- B = ALU_Bin_SEL ? Immed : RF_B, sampled at accept.
- Opcodes. All results are truncated to WIDTH bits; shifts and rotates are by 1 position.
  - 0000 A+B
  - 0001 A−B
  - 0010 A&B
  - 0011 A|B
  - 0100 ~A
  - 0110 A^B
  - 0111 A*B, low WIDTH bits (MUL_EN = 1)
  - 1000 arithmetic right shift of A (MSB replicated)
  - 1001 logical right shift of A
  - 1010 left shift of A
  - 1100 rotate A left
  - 1101 rotate A right
  - All other codes (and 0111 when MUL_EN = 0): result 0, Zero_out = 1, Ovf_out = 0, single-cycle.
- Ovf_out:
  - Add: (A[msb] == B[msb]) && (R[msb] != A[msb]).
  - Sub: (A[msb] != B[msb]) && (R[msb] != A[msb]).
  - All other operations: 0.
- Single-cycle operations: the result is loaded into the output registers on the accept edge. Out_valid = 1 in the cycle after accept (latency 1). State stays IDLE, so back-to-back throughput is 1 per cycle when Out_ready = 1.
- Multiply state machine (IDLE, MUL):
  - Accept of 0111: latch multiplicand = A, multiplier = B, acc = 0, cnt = 0, go to MUL. The output registers are not written on this edge.
  - MUL, each edge: if multiplier[0], acc += multiplicand; multiplicand <<= 1; multiplier >>= 1; cnt++. All values are WIDTH bits and wrap.
  - On the edge where cnt reaches WIDTH−1: load ALU_out = final acc, Zero_out, Ovf_out = 0, Out_valid = 1, return to IDLE.
  - Out_valid first asserts WIDTH+1 cycles after the accept cycle.
  - In_ready = 0 throughout MUL. The output register is guaranteed free at completion because accept required the output to be empty or draining.
- A consumer stall (Out_ready = 0) holds In_ready low once Out_valid = 1; no result is ever overwritten or lost.
- In_valid while In_ready = 0: not accepted; the upstream stage must hold its inputs.

Test Plan:
- Reset: assert Reset_n = 0 mid-operation, asynchronously, without a clock edge → Out_valid = 0, ALU_out = 0, Zero_out = 0, Ovf_out = 0 immediately; In_ready = 1 after release.
- Add with overflow and Immed select (WIDTH = 32, Out_ready = 1):
  - A = 0x7FFFFFFF, Immed = 1, ALU_Bin_SEL = 1, func 0000 → next cycle ALU_out = 0x80000000, Ovf_out = 1, Zero_out = 0.
  - Then func 0001 with A = B = 0x12345678 → ALU_out = 0, Zero_out = 1, Ovf_out = 0.
- Back-to-back throughput: issue AND, OR, XOR, SRA (A = 0x80000001) on consecutive cycles → 4 results on 4 consecutive cycles: 0x…, 0x…, 0x…, 0xC0000000. In_ready stays 1.
- Stall: Out_ready = 0 after the first result → In_ready = 0, ALU_out held stable for 5 cycles. Raise Out_ready → drain and new accept occur on the same edge.
- Multiply: A = 0xFFFFFFFF, B = 3, func 0111 → In_ready = 0 for 32 cycles, Out_valid high at cycle 33 with ALU_out = 0xFFFFFFFD.
  - Then A = 0x10000, B = 0x10000 → ALU_out = 0, Zero_out = 1.
- Unsupported/disabled opcodes: func 1111, and func 0111 with MUL_EN = 0 → 1-cycle latency, ALU_out = 0, Zero_out = 1.
  - Rotate right A = 0x00000001 → 0x80000000.
